foc_sequencer: RTL

FOC_SEQUENCER -- requirements
Module: foc_sequencer

---
 rtl/foc_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/foc_sequencer.sv
// Sequences one FOC control cycle per PWM trigger: ADC -> Clarke/Park -> PI -> inverse Park -> SVPWM.
// Each stage gets a one-cycle start pulse and a bounded wait for its done; overrun and timeout are reported.
module foc_sequencer #(
    parameter int TIMEOUT = 255
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iRun,
    input  logic       iTrig,
    input  logic       iClr_fault,
    input  logic       iAdc_done,
    input  logic       iCP_done,
    input  logic       iPI_done,
    input  logic       iIP_done,
    input  logic       iSV_done,
    output logic       oAdc_en,
    output logic       oCP_en,
    output logic       oPI_en,
    output logic       oIP_en,
    output logic       oSV_en,
    output logic [2:0] oStage,
    output logic       oBusy,
    output logic       oCycle_done,
    output logic       oOverrun,
    output logic       oFault,
    output logic [2:0] oFault_stage
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADC   = 3'd1,
        S_CP    = 3'd2,
        S_PI    = 3'd3,
        S_IP    = 3'd4,
        S_SV    = 3'd5,
        S_BAD   = 3'd6,
        S_FAULT = 3'd7
    } state_t;

    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    state_t     state;
    logic [7:0] wait_cnt;
    logic       trig_q;
    logic       trig_arm;
    logic [4:0] en_q;
    logic       trig_edge;
    logic       stage_done;

    // trig_arm blocks the first post-reset sample so a trigger already high at release is not an edge
    assign trig_edge = iTrig & ~trig_q & trig_arm;

    always_comb begin
        stage_done = 1'b0;
        case (state)
            S_ADC:   stage_done = iAdc_done;
            S_CP:    stage_done = iCP_done;
            S_PI:    stage_done = iPI_done;
            S_IP:    stage_done = iIP_done;
            S_SV:    stage_done = iSV_done;
            default: stage_done = 1'b0;
        endcase
    end

    function automatic state_t next_stage(input state_t s);
        case (s)
            S_ADC:   return S_CP;
            S_CP:    return S_PI;
            S_PI:    return S_IP;
            S_IP:    return S_SV;
            default: return S_IDLE;
        endcase
    endfunction

    // en_q bit k belongs to stage code k+1
    function automatic logic [4:0] stage_en(input state_t s);
        case (s)
            S_ADC:   return 5'b00001;
            S_CP:    return 5'b00010;
            S_PI:    return 5'b00100;
            S_IP:    return 5'b01000;
            S_SV:    return 5'b10000;
            default: return 5'b00000;
        endcase
    endfunction

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state        <= S_IDLE;
            wait_cnt     <= 8'd0;
            trig_q       <= 1'b0;
            trig_arm     <= 1'b0;
            en_q         <= 5'd0;
            oBusy        <= 1'b0;
            oCycle_done  <= 1'b0;
            oOverrun     <= 1'b0;
            oFault       <= 1'b0;
            oFault_stage <= 3'd0;
        end else begin
            trig_q      <= iTrig;
            trig_arm    <= 1'b1;
            en_q        <= 5'd0;
            oCycle_done <= 1'b0;
            oOverrun    <= 1'b0;

            case (state)
                S_IDLE: begin
                    wait_cnt <= 8'd0;
                    if (trig_edge && iRun) begin
                        state <= S_ADC;
                        en_q  <= stage_en(S_ADC);
                        oBusy <= 1'b1;
                    end
                end

                S_ADC, S_CP, S_PI, S_IP, S_SV: begin
                    // a trigger while busy is dropped and only reported; the sequence keeps going
                    if (trig_edge)
                        oOverrun <= 1'b1;
                    if (stage_done) begin
                        wait_cnt <= 8'd0;
                        if (state == S_SV) begin
                            state       <= S_IDLE;
                            oBusy       <= 1'b0;
                            oCycle_done <= 1'b1;
                        end else begin
                            state <= next_stage(state);
                            en_q  <= stage_en(next_stage(state));
                        end
                    end else if (wait_cnt == TO_CNT) begin
                        state        <= S_FAULT;
                        wait_cnt     <= 8'd0;
                        oBusy        <= 1'b0;
                        oFault       <= 1'b1;
                        oFault_stage <= state;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                S_FAULT: begin
                    wait_cnt <= 8'd0;
                    if (iClr_fault) begin
                        state        <= S_IDLE;
                        oFault       <= 1'b0;
                        oFault_stage <= 3'd0;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    wait_cnt <= 8'd0;
                    oBusy    <= 1'b0;
                end
            endcase
        end
    end

    assign oStage  = state;
    assign oAdc_en = en_q[0];
    assign oCP_en  = en_q[1];
    assign oPI_en  = en_q[2];
    assign oIP_en  = en_q[3];
    assign oSV_en  = en_q[4];

endmodule
